shift_sequencer: RTL and testbench

Multi-cycle shift/rotate controller for the 16-bit shifter datapath in the execute stage. It accepts an operand, a 4-bit amount and a 2-bit op through a valid/ready handshake. It then sequences a single reusable shift stage through the 8/4/2/1 binary-weighted steps, one step per cycle, and presents the result through a valid/ready handshake. The pipeline flush squashes any operation in flight.

---
 rtl/shifter_pkg.sv | 51 +++++
 rtl/shift_stage.sv | 67 ++++++
 rtl/shift_sequencer.sv | 115 +++++++++++
 tb/tb_shift_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the execute-stage shift/rotate sequencer.
//   - operation encodings (rotate/shift, left/right)
//   - controller state encodings
//   - one-hot step weights for the 8/4/2/1 sequence plus small pick helpers
package shifter_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SHL = 2'b01,
        OP_ROR = 2'b10,
        OP_SHR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    localparam logic [AMT_W-1:0] W_8 = 4'b1000;
    localparam logic [AMT_W-1:0] W_4 = 4'b0100;
    localparam logic [AMT_W-1:0] W_2 = 4'b0010;
    localparam logic [AMT_W-1:0] W_1 = 4'b0001;

    // Highest set bit of the remaining amount, as a one-hot weight (0 if none).
    function automatic logic [AMT_W-1:0] pick_highest(input logic [AMT_W-1:0] amt);
        logic [AMT_W-1:0] w;
        if (amt[3])      w = W_8;
        else if (amt[2]) w = W_4;
        else if (amt[1]) w = W_2;
        else if (amt[0]) w = W_1;
        else             w = '0;
        return w;
    endfunction

    // Fixed-walk weight: step 0 -> 8, 1 -> 4, 2 -> 2, 3 -> 1.
    function automatic logic [AMT_W-1:0] step_weight(input logic [1:0] step);
        logic [AMT_W-1:0] w;
        case (step)
            2'd0:    w = W_8;
            2'd1:    w = W_4;
            2'd2:    w = W_2;
            default: w = W_1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Single combinational shift/rotate stage, reused by the sequencer every
// SHIFT cycle.
//   stage_in  : operand
//   weight    : one-hot shift distance (8/4/2/1); all-zero passes the operand through
//   op        : rotl / shl / rotr / shr
//   stage_out : result
module shift_stage
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0] stage_in,
    input  logic [AMT_W-1:0]  weight,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] stage_out
);

    logic [DATA_W-1:0] rotl;
    logic [DATA_W-1:0] shl;
    logic [DATA_W-1:0] rotr;
    logic [DATA_W-1:0] shr;

    // Per-weight candidate row; the op then selects one of the four.
    always_comb begin
        rotl = stage_in;
        shl  = stage_in;
        rotr = stage_in;
        shr  = stage_in;
        case (weight)
            W_8: begin
                rotl = {stage_in[7:0], stage_in[15:8]};
                shl  = {stage_in[7:0], 8'h00};
                rotr = {stage_in[7:0], stage_in[15:8]};
                shr  = {8'h00, stage_in[15:8]};
            end
            W_4: begin
                rotl = {stage_in[11:0], stage_in[15:12]};
                shl  = {stage_in[11:0], 4'h0};
                rotr = {stage_in[3:0], stage_in[15:4]};
                shr  = {4'h0, stage_in[15:4]};
            end
            W_2: begin
                rotl = {stage_in[13:0], stage_in[15:14]};
                shl  = {stage_in[13:0], 2'b00};
                rotr = {stage_in[1:0], stage_in[15:2]};
                shr  = {2'b00, stage_in[15:2]};
            end
            W_1: begin
                rotl = {stage_in[14:0], stage_in[15]};
                shl  = {stage_in[14:0], 1'b0};
                rotr = {stage_in[0], stage_in[15:1]};
                shr  = {1'b0, stage_in[15:1]};
            end
            default: ;
        endcase
    end

    always_comb begin
        stage_out = stage_in;
        case (op)
            OP_ROL:  stage_out = rotl;
            OP_SHL:  stage_out = shl;
            OP_ROR:  stage_out = rotr;
            OP_SHR:  stage_out = shr;
            default: stage_out = stage_in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller for the 16-bit execute-stage shifter.
// A request (operand, 4-bit amount, 2-bit op) is taken over a valid/ready
// handshake, then one shared shift stage is stepped through the 8/4/2/1
// weights, one per cycle, and the result is offered over valid/ready.
//   clk, rst           : clock, asynchronous active-high reset
//   flush              : squashes any operation in flight
//   in_valid/in_ready  : request handshake; in_data, in_amt, in_op
//   out_valid/out_ready: result handshake; out_data
//   busy               : controller not idle
// SKIP_ZERO_STEPS=1 skips weights whose amount bit is clear (latency 1+popcount);
// SKIP_ZERO_STEPS=0 always walks all four weights (fixed latency).
module shift_sequencer
    import shifter_pkg::*;
#(
    parameter bit SKIP_ZERO_STEPS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        step_q, step_d;

    logic [AMT_W-1:0]  weight;
    logic [AMT_W-1:0]  amt_left;
    logic [DATA_W-1:0] stage_out;

    // In fixed-walk mode the weight is masked by the amount bit, so a clear
    // bit drives an all-zero weight and the stage passes data through.
    always_comb begin
        if (SKIP_ZERO_STEPS) weight = pick_highest(amt_q);
        else                 weight = step_weight(step_q) & amt_q;
        amt_left = amt_q & ~weight;
    end

    shift_stage u_stage (
        .stage_in  (data_q),
        .weight    (weight),
        .op        (op_q),
        .stage_out (stage_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            op_q    <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            op_q    <= op_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        op_d    = op_q;
        step_d  = step_q;
        // flush wins over both handshakes in the same cycle
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_d  = in_data;
                        amt_d   = in_amt;
                        op_d    = in_op;
                        step_d  = 2'd0;
                        state_d = ((in_amt != '0) || !SKIP_ZERO_STEPS) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    data_d = stage_out;
                    amt_d  = amt_left;
                    step_d = step_q + 2'd1;
                    if (SKIP_ZERO_STEPS) begin
                        if (amt_left == '0) state_d = S_DONE;
                    end else begin
                        if (step_q == 2'd3) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !flush;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam logic [1:0] ROL = 2'b00, SHL = 2'b01, ROR = 2'b10, SHR = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_amt = '0;
    logic [1:0]  in_op = '0;
    logic        out_ready = 1'b1;

    // a: SKIP_ZERO_STEPS=1, b: SKIP_ZERO_STEPS=0; both see the same inputs
    logic        in_ready_a, out_valid_a, busy_a;
    logic [15:0] out_data_a;
    logic        in_ready_b, out_valid_b, busy_b;
    logic [15:0] out_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.SKIP_ZERO_STEPS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .busy(busy_a)
    );

    shift_sequencer #(.SKIP_ZERO_STEPS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .busy(busy_b)
    );

    // Whole-amount reference: one shift/rotate by amt on a doubled word.
    function automatic logic [15:0] ref_op(input logic [15:0] x, input int amt, input logic [1:0] op);
        logic [31:0] d;
        logic [15:0] r;
        d = {x, x};
        case (op)
            ROL: begin d = d << amt; r = d[31:16]; end
            SHL: r = x << amt;
            ROR: begin d = d >> amt; r = d[15:0]; end
            default: r = x >> amt;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({in_ready_a, out_valid_a, busy_a, out_data_a} !== {3'b100, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_a: got rdy=%b vld=%b busy=%b data=%h, want 1 0 0 0000",
                     in_ready_a, out_valid_a, busy_a, out_data_a);
        end
        n_checks++;
        if ({in_ready_b, out_valid_b, busy_b, out_data_b} !== {3'b100, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_b: got rdy=%b vld=%b busy=%b data=%h, want 1 0 0 0000",
                     in_ready_b, out_valid_b, busy_b, out_data_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One request with out_ready held high; checks data and latency of both variants.
    task automatic run_op(input logic [15:0] d, input logic [3:0] a, input logic [1:0] op);
        logic [15:0] expd, got_a, got_b;
        int exp_a, lat_a, lat_b;
        expd  = ref_op(d, int'(a), op);
        exp_a = 1 + $countones(a);
        got_a = 'x;
        got_b = 'x;
        lat_a = -1;
        lat_b = -1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_op     = op;
        @(negedge clk);
        n_checks++;
        if ({in_ready_a, in_ready_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL accept_ready: got %b%b, want 11", in_ready_a, in_ready_b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_amt   = 4'($urandom);
        in_op    = 2'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (out_valid_a && lat_a < 0) begin lat_a = k; got_a = out_data_a; end
            if (out_valid_b && lat_b < 0) begin lat_b = k; got_b = out_data_b; end
            if (k == exp_a) begin
                n_checks++;
                if (in_ready_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ready_low_in_done: got %b, want 0", in_ready_a);
                end
            end
            if (k == exp_a + 1) begin
                n_checks++;
                if (in_ready_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_after_done: got %b, want 1", in_ready_a);
                end
            end
        end
        n_checks++;
        if (lat_a != exp_a || got_a !== expd) begin
            n_fail++;
            $display("FAIL op_skip d=%h a=%0d op=%0d: got %h lat %0d, want %h lat %0d",
                     d, a, op, got_a, lat_a, expd, exp_a);
        end
        n_checks++;
        if (lat_b != 5 || got_b !== expd) begin
            n_fail++;
            $display("FAIL op_fixed d=%h a=%0d op=%0d: got %h lat %0d, want %h lat 5",
                     d, a, op, got_b, lat_b, expd);
        end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 4'd4, ROL);
        run_op(16'h8001, 4'd5, ROR);
        run_op(16'hF000, 4'd15, SHR);
        run_op(16'h00FF, 4'd0, SHL);
        run_op(16'h8000, 4'd15, ROL);
        run_op(16'hFFFF, 4'd15, SHL);
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_amt    = 4'd4;
        in_op     = ROL;
        @(posedge clk); #1;
        in_data = 16'hBEEF;
        in_amt  = 4'd3;
        in_op   = SHL;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (out_valid_a && out_valid_b) break;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({out_valid_a, out_valid_b, in_ready_a, in_ready_b} !== 4'b1100 ||
                out_data_a !== 16'h2341 || out_data_b !== 16'h2341) begin
                n_fail++;
                $display("FAIL backpressure_hold: got vld=%b%b rdy=%b%b data=%h/%h, want 11 00 2341",
                         out_valid_a, out_valid_b, in_ready_a, in_ready_b, out_data_a, out_data_b);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid_a, out_valid_b, in_ready_a, in_ready_b, busy_a, busy_b} !== 6'b001100) begin
            n_fail++;
            $display("FAIL backpressure_release: got vld=%b%b rdy=%b%b busy=%b%b, want 00 11 00",
                     out_valid_a, out_valid_b, in_ready_a, in_ready_b, busy_a, busy_b);
        end
    endtask

    task automatic test_flush();
        logic seen;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'hF000;
        in_amt   = 4'd15;
        in_op    = SHR;
        @(posedge clk); #1;          // cycle c+1: first SHIFT
        in_valid = 1'b0;
        @(posedge clk); #1;          // cycle c+2: second SHIFT
        flush    = 1'b1;
        in_valid = 1'b1;             // must not be accepted during flush
        in_amt   = 4'd1;
        @(negedge clk);
        n_checks++;
        if ({in_ready_a, in_ready_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_ready: got %b%b, want 00", in_ready_a, in_ready_b);
        end
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_a, busy_b, in_ready_a, in_ready_b} !== 4'b0011) begin
            n_fail++;
            $display("FAIL flush_idle: got busy=%b%b rdy=%b%b, want 00 11",
                     busy_a, busy_b, in_ready_a, in_ready_b);
        end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid_a || out_valid_b) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_output: got out_valid seen=%b, want 0", seen);
        end
        run_op(16'hA5C3, 4'd9, ROR);
    endtask

    task automatic test_rst_mid();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'h1357;
        in_amt   = 4'd15;
        in_op    = ROL;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b} !== 6'b100100) begin
            n_fail++;
            $display("FAIL rst_mid: got a=%b%b%b b=%b%b%b, want 100 100",
                     in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        run_op(16'h0F0F, 4'd6, SHL);
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++)
            run_op(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
